// File: rtl/shift_register_piso_tx.sv
`default_nettype none
// ============================================================================
//  Module   : shift_register_piso_tx
//  Brief    : Parallel-in serial-out transmitter with valid/ready word intake,
//             bit-valid and last-bit qualifiers, and optional inter-word gap.
//  Revision : 1.0 - initial release
// ============================================================================
module shift_register_piso_tx #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 1,
    parameter int GAP       = 0
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [WIDTH-1:0] din_data,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);

    localparam int                 c_CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST     = c_CNT_W'(WIDTH - 1);
    localparam bit                 c_NO_GAP   = (GAP == 0);
    localparam logic [3:0]         c_GAP_INIT = (GAP > 0) ? 4'(GAP - 1) : 4'd0;
    localparam bit                 c_MSB      = (MSB_FIRST != 0);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t             r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_gap;
    logic [WIDTH-1:0]   r_shreg;
    logic               r_sout;
    logic               r_sout_valid;
    logic               r_sout_last;
    logic               r_busy;

    logic               w_last_bit;
    logic               w_ready;
    logic               w_accept;

    // Bit that leaves the word first, and the word with that bit consumed.
    function automatic logic f_head(input logic [WIDTH-1:0] v);
        return c_MSB ? v[WIDTH-1] : v[0];
    endfunction

    function automatic logic [WIDTH-1:0] f_advance(input logic [WIDTH-1:0] v);
        return c_MSB ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
    endfunction

    assign w_last_bit = (r_state == S_SHIFT) && (r_cnt == c_LAST);
    assign w_ready    = !clr && ((r_state == S_IDLE) || (w_last_bit && c_NO_GAP));
    assign w_accept   = w_ready && din_valid;

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_gap        <= '0;
            r_shreg      <= '0;
            r_sout       <= 1'b0;
            r_sout_valid <= 1'b0;
            r_sout_last  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_state      <= S_SHIFT;
                        r_cnt        <= '0;
                        r_shreg      <= f_advance(din_data);
                        r_sout       <= f_head(din_data);
                        r_sout_valid <= 1'b1;
                        r_sout_last  <= 1'b0;
                        r_busy       <= 1'b1;
                    end else begin
                        r_sout       <= 1'b0;
                        r_sout_valid <= 1'b0;
                        r_sout_last  <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end

                S_SHIFT: begin
                    if (!w_last_bit) begin
                        r_cnt        <= r_cnt + 1'b1;
                        r_shreg      <= f_advance(r_shreg);
                        r_sout       <= f_head(r_shreg);
                        r_sout_valid <= 1'b1;
                        r_sout_last  <= ((r_cnt + 1'b1) == c_LAST);
                        r_busy       <= 1'b1;
                    end else if (!c_NO_GAP) begin
                        r_state      <= S_GAP;
                        r_cnt        <= '0;
                        r_gap        <= c_GAP_INIT;
                        r_sout       <= 1'b0;
                        r_sout_valid <= 1'b0;
                        r_sout_last  <= 1'b0;
                        r_busy       <= 1'b1;
                    end else if (w_accept) begin
                        // Reload on the last-bit edge keeps the serial stream gapless.
                        r_state      <= S_SHIFT;
                        r_cnt        <= '0;
                        r_shreg      <= f_advance(din_data);
                        r_sout       <= f_head(din_data);
                        r_sout_valid <= 1'b1;
                        r_sout_last  <= 1'b0;
                        r_busy       <= 1'b1;
                    end else begin
                        r_state      <= S_IDLE;
                        r_cnt        <= '0;
                        r_sout       <= 1'b0;
                        r_sout_valid <= 1'b0;
                        r_sout_last  <= 1'b0;
                        r_busy       <= 1'b0;
                    end
                end

                S_GAP: begin
                    r_sout       <= 1'b0;
                    r_sout_valid <= 1'b0;
                    r_sout_last  <= 1'b0;
                    if (r_gap == 4'd0) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_gap   <= r_gap - 1'b1;
                        r_busy  <= 1'b1;
                    end
                end

                default: begin
                    r_state      <= S_IDLE;
                    r_cnt        <= '0;
                    r_gap        <= '0;
                    r_sout       <= 1'b0;
                    r_sout_valid <= 1'b0;
                    r_sout_last  <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready  = w_ready;
    assign sout       = r_sout;
    assign sout_valid = r_sout_valid;
    assign sout_last  = r_sout_last;
    assign busy       = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_shift_register_piso_tx.sv
`default_nettype none
// ============================================================================
//  Module   : tb_shift_register_piso_tx
//  Brief    : Directed bench for shift_register_piso_tx in three configurations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_shift_register_piso_tx;

    logic       clk;
    logic       clr;

    // u_msb: MSB first, no gap. u_lsb: LSB first, no gap. u_gap: MSB first, GAP=2.
    logic [3:0] m_data, l_data, g_data;
    logic       m_valid, l_valid, g_valid;
    logic       m_ready, l_ready, g_ready;
    logic       m_sout, l_sout, g_sout;
    logic       m_sv, l_sv, g_sv;
    logic       m_last, l_last, g_last;
    logic       m_busy, l_busy, g_busy;

    int checks;
    int errors;

    logic [3:0] exp_msb;
    logic [3:0] exp_lsb;
    logic [7:0] exp_b2b;
    logic [3:0] exp_w2;

    shift_register_piso_tx #(.WIDTH(4), .MSB_FIRST(1), .GAP(0)) u_msb (
        .clk(clk), .clr(clr), .din_data(m_data), .din_valid(m_valid), .din_ready(m_ready),
        .sout(m_sout), .sout_valid(m_sv), .sout_last(m_last), .busy(m_busy)
    );

    shift_register_piso_tx #(.WIDTH(4), .MSB_FIRST(0), .GAP(0)) u_lsb (
        .clk(clk), .clr(clr), .din_data(l_data), .din_valid(l_valid), .din_ready(l_ready),
        .sout(l_sout), .sout_valid(l_sv), .sout_last(l_last), .busy(l_busy)
    );

    shift_register_piso_tx #(.WIDTH(4), .MSB_FIRST(1), .GAP(2)) u_gap (
        .clk(clk), .clr(clr), .din_data(g_data), .din_valid(g_valid), .din_ready(g_ready),
        .sout(g_sout), .sout_valid(g_sv), .sout_last(g_last), .busy(g_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks  = 0;
        errors  = 0;
        exp_msb = 4'b1011;
        exp_lsb = 4'b1101;
        exp_b2b = 8'b1011_0110;
        exp_w2  = 4'b0110;
        clr     = 1'b1;
        m_data  = '0; l_data = '0; g_data = '0;
        m_valid = 1'b0; l_valid = 1'b0; g_valid = 1'b0;

        // Reset: two clr cycles, outputs low and ready held low
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk($sformatf("rst%0d_sout", i),  m_sout, 0);
            chk($sformatf("rst%0d_sv", i),    m_sv, 0);
            chk($sformatf("rst%0d_last", i),  m_last, 0);
            chk($sformatf("rst%0d_busy", i),  m_busy, 0);
            chk($sformatf("rst%0d_ready", i), m_ready, 0);
            chk($sformatf("rst%0d_gready", i), g_ready, 0);
        end
        clr = 1'b0;
        #1;
        chk("rel_ready", m_ready, 1);
        chk("rel_lready", l_ready, 1);

        // Single word 1011 into both the MSB-first and LSB-first instances
        m_data = 4'b1011; m_valid = 1'b1;
        l_data = 4'b1011; l_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc();
            m_valid = 1'b0; l_valid = 1'b0;
            chk($sformatf("msb_b%0d_sout", i), m_sout, exp_msb[3-i]);
            chk($sformatf("msb_b%0d_sv", i),   m_sv, 1);
            chk($sformatf("msb_b%0d_last", i), m_last, (i == 3));
            chk($sformatf("msb_b%0d_ready", i), m_ready, (i == 3));
            chk($sformatf("lsb_b%0d_sout", i), l_sout, exp_lsb[3-i]);
            chk($sformatf("lsb_b%0d_sv", i),   l_sv, 1);
            chk($sformatf("lsb_b%0d_last", i), l_last, (i == 3));
        end
        cyc();
        chk("msb_end_sv", m_sv, 0);
        chk("msb_end_sout", m_sout, 0);
        chk("msb_end_busy", m_busy, 0);
        chk("msb_end_ready", m_ready, 1);
        chk("lsb_end_sv", l_sv, 0);

        // Back-to-back: 1011 then 0110 with valid held high
        m_data = 4'b1011; m_valid = 1'b1;
        #1;
        chk("b2b_idle_ready", m_ready, 1);
        for (int i = 0; i < 8; i++) begin
            cyc();
            if (i == 0) m_data = 4'b0110;
            if (i == 4) m_valid = 1'b0;
            chk($sformatf("b2b_b%0d_sout", i),  m_sout, exp_b2b[7-i]);
            chk($sformatf("b2b_b%0d_sv", i),    m_sv, 1);
            chk($sformatf("b2b_b%0d_last", i),  m_last, (i == 3 || i == 7));
            chk($sformatf("b2b_b%0d_ready", i), m_ready, (i == 3 || i == 7));
        end
        cyc();
        chk("b2b_end_sv", m_sv, 0);
        chk("b2b_end_busy", m_busy, 0);
        chk("b2b_end_ready", m_ready, 1);

        // Inter-word gap of 2 cycles
        g_data = 4'b1011; g_valid = 1'b1;
        #1;
        chk("gap_idle_ready", g_ready, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 0) g_data = 4'b0110;
            chk($sformatf("gap_w1b%0d_sout", i),  g_sout, exp_msb[3-i]);
            chk($sformatf("gap_w1b%0d_sv", i),    g_sv, 1);
            chk($sformatf("gap_w1b%0d_last", i),  g_last, (i == 3));
            chk($sformatf("gap_w1b%0d_ready", i), g_ready, 0);
        end
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk($sformatf("gap_g%0d_sv", i),    g_sv, 0);
            chk($sformatf("gap_g%0d_sout", i),  g_sout, 0);
            chk($sformatf("gap_g%0d_busy", i),  g_busy, 1);
            chk($sformatf("gap_g%0d_ready", i), g_ready, 0);
        end
        cyc();
        chk("gap_idle_sv", g_sv, 0);
        chk("gap_idle_busy", g_busy, 0);
        chk("gap_idle_ready2", g_ready, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 0) g_valid = 1'b0;
            chk($sformatf("gap_w2b%0d_sout", i), g_sout, exp_w2[3-i]);
            chk($sformatf("gap_w2b%0d_sv", i),   g_sv, 1);
            chk($sformatf("gap_w2b%0d_last", i), g_last, (i == 3));
        end
        cyc();
        chk("gap_tail_sv", g_sv, 0);
        chk("gap_tail_busy", g_busy, 1);

        // Reset mid-word with the producer still presenting 1011
        m_data = 4'b1011; m_valid = 1'b1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            chk($sformatf("mid_b%0d_sout", i),  m_sout, exp_msb[3-i]);
            chk($sformatf("mid_b%0d_ready", i), m_ready, 0);
        end
        clr = 1'b1;
        #1;
        chk("mid_clr_ready", m_ready, 0);
        cyc();
        chk("mid_clr_sv", m_sv, 0);
        chk("mid_clr_sout", m_sout, 0);
        chk("mid_clr_busy", m_busy, 0);
        chk("mid_clr_last", m_last, 0);
        clr = 1'b0;
        #1;
        chk("mid_rel_ready", m_ready, 1);
        for (int i = 0; i < 4; i++) begin
            cyc();
            if (i == 0) m_valid = 1'b0;
            chk($sformatf("mid_rs%0d_sout", i), m_sout, exp_msb[3-i]);
            chk($sformatf("mid_rs%0d_sv", i),   m_sv, 1);
            chk($sformatf("mid_rs%0d_last", i), m_last, (i == 3));
        end
        cyc();
        chk("mid_end_sv", m_sv, 0);
        chk("mid_end_ready", m_ready, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
